// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: applies one binary-weighted stage (1,2,4,8,16) per clock
// under a start/busy/done handshake. Supports SLL, SRL, SRA and ROL.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | processing one shift stage per edge, stg_q selects the stage
// DONE  | one-cycle completion, done=1; start here is accepted back-to-back
module shift_sequencer #(
   parameter bit EARLY_DONE = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] data_in,
   input  logic [4:0]  shamt,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   state_t      state_q;
   logic [31:0] work_q;
   logic [31:0] work_d;
   logic [31:0] result_q;
   logic [4:0]  amt_q;
   logic [1:0]  opr_q;
   logic [2:0]  stg_q;
   logic        busy_q;
   logic        done_q;

   logic        stage_en;
   logic        last_stage;
   logic [4:0]  above_mask;
   logic [4:0]  stage_dist;
   logic [31:0] shifted;

   always_comb begin
      stage_dist = 5'd1 << stg_q;
      shifted    = work_q;
      case (opr_q)
         OP_SLL:  shifted = work_q << stage_dist;
         OP_SRL:  shifted = work_q >> stage_dist;
         OP_SRA:  shifted = $unsigned($signed(work_q) >>> stage_dist);
         OP_ROL:  shifted = (work_q << stage_dist) | (work_q >> (6'd32 - {1'b0, stage_dist}));
         default: shifted = work_q;
      endcase
   end

   // Early exit looks only at the amount bits above the current stage.
   always_comb begin
      stage_en   = |((amt_q >> stg_q) & 5'd1);
      above_mask = 5'b11110 << stg_q;
      last_stage = (stg_q == 3'd4) || (EARLY_DONE && ((amt_q & above_mask) == 5'd0));
      work_d     = stage_en ? shifted : work_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         work_q   <= '0;
         result_q <= '0;
         amt_q    <= '0;
         opr_q    <= '0;
         stg_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  work_q  <= data_in;
                  amt_q   <= shamt;
                  opr_q   <= op;
                  stg_q   <= '0;
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            end
            RUN: begin
               work_q <= work_d;
               stg_q  <= stg_q + 3'd1;
               if (last_stage) begin
                  result_q <= work_d;
                  state_q  <= DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift engine for the single-cycle datapath's shift resource. It applies a 5-bit shift amount to a 32-bit operand one binary-weighted stage per clock: 1, 2, 4, 8, then 16 positions. It supports logical-left, logical-right, arithmetic-right and rotate-left. It is controlled by a start/busy/done handshake, so the control unit can share one shifter stage instead of five cascaded mux ranks.

## Interface
- EARLY_DONE, default 0: when 1, finish as soon as no higher shamt bits remain; when 0, latency is fixed.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a shift; sampled only when the block can accept.
- op  input  2  operation select:
  - 00 = SLL
  - 01 = SRL
  - 10 = SRA
  - 11 = ROL
- data_in  input  32  operand, captured on acceptance.
- shamt  input  5  shift amount, captured on acceptance.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse when result is updated.
- result  output  32  last completed result; held until the next completion.

## Operation
- States are IDLE, RUN and DONE. Internal registers:
  - work[31:0], the working operand
  - amt[4:0], the captured shift amount
  - opr[1:0], the captured operation
  - stg[2:0], the stage counter
- Acceptance: start=1 while the state is IDLE or DONE.
  - On the accepting edge: work←data_in, amt←shamt, opr←op, stg←0, state←RUN.
  - start while in RUN is ignored; no queueing.
- RUN, each edge: if amt[stg]=1, shift work by 2^stg positions per opr; otherwise work is unchanged.
  - SLL: zero fill from the LSB side.
  - SRL: zero fill from the MSB side.
  - SRA: fill with work[31]; the sign is re-read each stage, and is equivalent to the original bit 31.
  - ROL: bits leaving bit 31 re-enter at bit 0.
  - Then stg←stg+1.
- Leaving RUN on the same edge that processes stage 4 (EARLY_DONE=0):
  - result←final shifted value
  - state←DONE
- EARLY_DONE=1: leave RUN on the edge processing stage k when amt bits above k are all zero.
  - shamt=0 exits on the first RUN edge, with result=data_in.
- DONE lasts one cycle; the next state is IDLE, or RUN if start=1.
- All arithmetic is modulo 32 bits. shamt ranges 0..31; a shift of 32 or more cannot be expressed.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, result=0, and all internal registers 0. Reset takes effect immediately, including mid-RUN; the aborted operation produces no done.
- Edge E0 accepts the request. busy=1 from E0 through the exit edge.
- EARLY_DONE=0:
  - Stages are processed on edges E1..E5.
  - done=1 and the new result are visible from E5 to E6.
  - Latency is 5 cycles.
- EARLY_DONE=1:
  - Exit is on edge E(m+1), where m is the index of the highest set bit of shamt (m=0 when shamt=0).
  - Latency is 1 to 5 cycles.
- busy is combinationally equivalent to (state==RUN), and is registered.
- done is registered and high only in the DONE state.
- Back-to-back: start=1 in the DONE cycle is accepted at that cycle's ending edge. The following cycle then has busy=1, done=0.
- result changes only at the exit edge. It never shows intermediate stage values.
- op, data_in and shamt may change freely after acceptance without affecting the in-flight operation.

## Test plan
- Reset then SLL, EARLY_DONE=0: data_in=0x0000_0001, shamt=31.
  - Required: busy for 5 cycles, then done pulse with result=0x8000_0000.
- SRA, SRL and ROL (one operation each):
  - SRA, data_in=0x8000_0000, shamt=4 → result=0xF800_0000.
  - SRL, data_in=0x8000_0000, shamt=4 → result=0x0800_0000.
  - ROL, data_in=0x8000_0001, shamt=1 → result=0x0000_0003.
  - Each completes in 5 cycles.
- Start while busy: issue SLL 0x1, shamt=2. Pulse start with data_in=0xFFFF_FFFF two cycles later.
  - Required: exactly one done, result=0x0000_0004.
- Back-to-back: assert start in the DONE cycle with SRL 0xF000_0000, shamt=8.
  - Required: busy on the next cycle, second done 5 cycles later with result=0x00F0_0000.
- Reset mid-operation: drop rst_n asynchronously at RUN stage 2.
  - Required: busy=0, done=0 and result=0 immediately.
  - No done after release until a new start.
- EARLY_DONE=1 (one operation each):
  - SLL 0x1, shamt=3 → done after 2 cycles, result=0x0000_0008.
  - shamt=0 → done after 1 cycle, result=data_in.
  - shamt=16 → done after 5 cycles.
